// File: rtl/lm70_pkg.sv
// lm70_pkg: shared types and frame field positions for the LM70 read sequencer.
package lm70_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_UPDATE,
    ST_WAIT
  } state_t;
  localparam int LM70_FRAME_BITS = 16;
  localparam int TEMP_MSB = 15;
  localparam int TEMP_LSB = 7;
  localparam int ID_MSB = 4;
  localparam int ID_LSB = 2;
  localparam logic [2:0] ID_VAL = 3'b111;
endpackage

// File: rtl/lm70_sck_gen.sv
// lm70_sck_gen: registered SCK with CLK_DIV-cycle half periods and edge strobes.
module lm70_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise,
  output logic o_fall
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] r_cnt;
  logic          r_sck;
  logic          w_wrap;
  // Strobes fire in the cycle whose closing edge moves the registered sck.
  assign w_wrap = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_rise = w_wrap && !r_sck;
  assign o_fall = w_wrap && r_sck;
  assign o_sck  = r_sck;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (!i_en) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      r_sck <= w_wrap ? !r_sck : r_sck;
    end
  end
endmodule

// File: rtl/lm70_ctrl.sv
// lm70_ctrl: periodic LM70 frame reader with hysteretic over-temperature flag.
module lm70_ctrl
  import lm70_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_CYCLES = 1000,
  parameter int HYST          = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] setpoint,
  input  logic       sio,
  output logic       sck,
  output logic       cs_n,
  output logic [8:0] temp_out,
  output logic       temp_valid,
  output logic       over_temp,
  output logic       frame_err,
  output logic       busy
);
  localparam int CMAX = (SAMPLE_CYCLES > CLK_DIV) ? SAMPLE_CYCLES : CLK_DIV;
  localparam int CW   = $clog2(CMAX + 1);
  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [4:0]       r_bits;
  logic [15:0]      r_sr;
  logic             r_cs_n, r_valid, r_over, r_err;
  logic [8:0]       r_temp;
  logic             w_rise, w_fall, w_sck, w_cs_n_d, w_busy;
  logic             w_div_done, w_wait_done, w_id_ok, w_over_d;
  logic [8:0]       w_temp;
  logic signed [9:0] w_t, w_s, w_sh;
  lm70_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_state == ST_SHIFT),
    .o_sck (w_sck),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );
  assign w_div_done  = r_cnt == CW'(CLK_DIV - 1);
  assign w_wait_done = r_cnt == CW'(SAMPLE_CYCLES);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     w_next = en ? ST_CS_SETUP : ST_IDLE;
      ST_CS_SETUP: w_next = w_div_done ? ST_SHIFT : ST_CS_SETUP;
      ST_SHIFT:    w_next = (w_fall && r_bits == 5'(LM70_FRAME_BITS)) ? ST_CS_HOLD : ST_SHIFT;
      ST_CS_HOLD:  w_next = w_div_done ? ST_UPDATE : ST_CS_HOLD;
      ST_UPDATE:   w_next = en ? ST_WAIT : ST_IDLE;
      ST_WAIT:     w_next = w_wait_done ? (en ? ST_CS_SETUP : ST_IDLE) : ST_WAIT;
      default:     w_next = ST_IDLE;
    endcase
  end
  // cs_n is registered from the next state so it lands exactly on state entry.
  always_comb begin
    w_cs_n_d = !(w_next inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
    w_busy   = r_state inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD, ST_UPDATE};
  end
  assign w_temp  = r_sr[TEMP_MSB:TEMP_LSB];
  assign w_id_ok = r_sr[ID_MSB:ID_LSB] == ID_VAL;
  assign w_t     = {w_temp[8], w_temp};
  assign w_s     = {{2{setpoint[7]}}, setpoint};
  assign w_sh    = w_s + 10'(HYST);
  assign w_over_d = (w_t >= w_sh) ? 1'b1 : (w_t < w_s) ? 1'b0 : r_over;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bits  <= '0;
      r_sr    <= '0;
      r_cs_n  <= 1'b1;
      r_valid <= 1'b0;
      r_over  <= 1'b0;
      r_err   <= 1'b0;
      r_temp  <= '0;
    end else begin
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_bits  <= (r_state != ST_SHIFT) ? '0 : r_bits + 5'(w_rise);
      r_sr    <= w_rise ? {r_sr[14:0], sio} : r_sr;
      r_cs_n  <= w_cs_n_d;
      r_valid <= r_state == ST_UPDATE;
      if (r_state == ST_UPDATE) begin
        r_err <= !w_id_ok;
        if (w_id_ok) begin
          r_temp <= w_temp;
          r_over <= w_over_d;
        end
      end
    end
  end
  assign sck        = w_sck;
  assign cs_n       = r_cs_n;
  assign temp_out   = r_temp;
  assign temp_valid = r_valid;
  assign over_temp  = r_over;
  assign frame_err  = r_err;
  assign busy       = w_busy;
endmodule

// File: tb/tb_lm70_ctrl.sv
// tb_lm70_ctrl: directed frames through an LM70 model, scoreboard checked on temp_valid.
module tb_lm70_ctrl;
  logic       clk = 1'b0, rst = 1'b1, en = 1'b0, sio = 1'b1;
  logic [7:0] setpoint = 8'd0;
  logic       sck, cs_n, temp_valid, over_temp, frame_err, busy;
  logic [8:0] temp_out;
  typedef struct {logic [8:0] t; logic o; logic e;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, cyc = 0, n_falls = 0, n_valid = 0, rises = 0, fall_cyc = 0;
  int idx = 0;
  logic [15:0] word = 16'h0;
  logic p_sck = 1'b0, p_cs = 1'b1, p_tv = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  lm70_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .setpoint(setpoint), .sio(sio),
    .sck(sck), .cs_n(cs_n), .temp_out(temp_out), .temp_valid(temp_valid),
    .over_temp(over_temp), .frame_err(frame_err), .busy(busy)
  );

  // LM70: first bit after CS falls, next bit after each SCK falling edge
  always @(negedge cs_n) begin
    idx = 15;
    sio = word[15];
  end
  always @(negedge sck) if (!cs_n) begin
    idx--;
    sio = (idx >= 0) ? word[idx] : 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (p_cs && !cs_n) begin
      n_falls++;
      fall_cyc = cyc;
      rises = 0;
    end
    if (sck && !p_sck && !cs_n) rises++;
    if (sck && cs_n) check("sck_while_cs_high", sck, 0);
    if (temp_valid) begin
      n_valid++;
      check("valid_single_pulse", p_tv, 0);
      check("latency", cyc - fall_cyc, 137);
      check("sck_rises", rises, 16);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got temp_valid=1 expected none");
      end else begin
        e = q.pop_front();
        check("temp_out", temp_out, e.t);
        check("over_temp", over_temp, e.o);
        check("frame_err", frame_err, e.e);
      end
    end
    p_cs = cs_n;
    p_sck = sck;
    p_tv = temp_valid;
  end

  task automatic wait_falls(input int bound);
    int s = n_falls;
    int k = 0;
    while (n_falls == s && k < bound) begin
      @(negedge clk); #1;
      k++;
    end
    check("cs_fall_seen", n_falls != s, 1);
  endtask

  task automatic wait_valid(input int bound);
    int s = n_valid;
    int k = 0;
    while (n_valid == s && k < bound) begin
      @(negedge clk); #1;
      k++;
    end
    check("valid_seen", n_valid != s, 1);
  endtask

  task automatic frame(input logic [15:0] w, input logic [7:0] sp, input logic [8:0] t,
                       input logic o, input logic e);
    word = w;
    setpoint = sp;
    q.push_back('{t, o, e});
    en = 1'b1;
    wait_falls(8);
    en = 1'b0;
    wait_valid(200);
    check("busy_after_frame", busy, 0);
  endtask

  initial begin
    int c1, k;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cs_n", cs_n, 1);
    check("rst_sck", sck, 0);
    check("rst_temp", temp_out, 0);
    check("rst_valid", temp_valid, 0);
    check("rst_over", over_temp, 0);
    check("rst_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    frame(16'h0C1F, 8'd24, 9'd24, 1'b0, 1'b0);
    frame(16'h0D1F, 8'd24, 9'd26, 1'b1, 1'b0);
    frame(16'h0C9F, 8'd24, 9'd25, 1'b1, 1'b0);
    frame(16'h0B9F, 8'd24, 9'd23, 1'b0, 1'b0);
    frame(16'hFD9F, 8'hFD, 9'h1FB, 1'b0, 1'b0);
    frame(16'h401F, 8'd127, 9'd128, 1'b0, 1'b0);
    frame(16'h0C1F, 8'h80, 9'd24, 1'b1, 1'b0);
    frame(16'h801F, 8'h80, 9'h100, 1'b0, 1'b0);
    frame(16'h0D1F, 8'd24, 9'd26, 1'b1, 1'b0);
    frame(16'h0C00, 8'd24, 9'd26, 1'b1, 1'b1);
    frame(16'h0C1F, 8'd24, 9'd24, 1'b1, 1'b0);
    // abort a frame with reset after the 7th SCK rise
    word = 16'h0C1F;
    en = 1'b1;
    wait_falls(8);
    k = 0;
    while (rises < 7 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    check("rises_before_rst", rises, 7);
    check("sck_high_before_rst", sck, 1);
    rst = 1'b1;
    #1;
    check("async_rst_cs_n", cs_n, 1);
    check("async_rst_sck", sck, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_temp", temp_out, 0);
    check("async_rst_over", over_temp, 0);
    en = 1'b0;
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    frame(16'h0C1F, 8'd24, 9'd24, 1'b0, 1'b0);
    // en dropped mid-frame returns straight to IDLE, so re-enabling starts at once
    en = 1'b1;
    q.push_back('{9'd24, 1'b0, 1'b0});
    wait_falls(2);
    c1 = fall_cyc;
    q.push_back('{9'd24, 1'b0, 1'b0});
    wait_falls(1200);
    check("frame_period", fall_cyc - c1, 34 * 4 + 2 + 1000);
    en = 1'b0;
    wait_valid(200);
    repeat (20) @(negedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_cs_n", cs_n, 1);
    check("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lm70_ctrl.md
Name: lm70_ctrl

Overview:
Master-side read sequencer for the LM70 3-wire temperature sensor. It periodically drops CS, generates SCK and shifts in the 16-bit sensor word from SIO, MSB first. It then extracts the integer temperature and compares it with a user setpoint, with hysteresis, to drive an over-temperature flag. It sits between the LM70 pins and the thermostat/fan logic and replaces the testbench's hand-driven CS and SCK.

Parameters:
CLK_DIV, 4, clk cycles per SCK half-period (>=2)
SAMPLE_CYCLES, 1000, idle clk cycles between the end of one frame and the start of the next
HYST, 2, hysteresis in whole degrees C (unsigned, 0..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  periodic sampling enable
setpoint  in  8  signed setpoint, whole degrees C
sio  in  1  LM70 SIO (read-only here; sensor owns the driver during a read)
sck  out  1  serial clock to LM70, idles low
cs_n  out  1  LM70 chip select, active-low
temp_out  out  9  signed temperature, whole degrees C = frame[15:7]
temp_valid  out  1  one-cycle pulse when temp_out/over_temp update
over_temp  out  1  hysteretic over-temperature flag
frame_err  out  1  sticky-until-next-frame: last frame had frame[4:2] != 3'b111
busy  out  1  high from CS_SETUP through UPDATE

Behaviour:
- Reset (async, immediate): cs_n=1, sck=0, temp_out=0, temp_valid=0, over_temp=0, frame_err=0, busy=0, state=IDLE, counters=0.
- FSM states: IDLE, CS_SETUP, SHIFT, CS_HOLD, UPDATE, WAIT.
- IDLE:
  - en=1 -> CS_SETUP next cycle; cs_n falls on entry.
  - en=0 -> stay in IDLE.
- CS_SETUP: cs_n=0, sck=0 for CLK_DIV cycles -> SHIFT.
- SHIFT: 16 SCK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
  - sio is sampled into the shift register on the clk cycle where sck goes 0->1; 16 samples in total, MSB first.
  - After the 16th high half, sck returns to 0 -> CS_HOLD.
- CS_HOLD: sck=0, cs_n=0 for CLK_DIV cycles, then cs_n=1 -> UPDATE.
- UPDATE (1 cycle), registered outputs valid the following cycle together with temp_valid=1:
  - If frame[4:2]==3'b111: frame_err=0, temp_out=frame[15:7], over_temp updated.
  - Otherwise: frame_err=1; temp_out and over_temp hold their previous values. temp_valid still pulses.
- over_temp rule (10-bit signed arithmetic, no overflow; T=temp, S=sign-extended setpoint):
  - set when T >= S+HYST
  - clear when T < S
  - otherwise hold
- WAIT: count SAMPLE_CYCLES cycles.
  - If en=1 at the end -> CS_SETUP.
  - If en=0 at the end -> IDLE.
- en deasserted mid-frame: the frame completes, including the UPDATE, then the FSM goes to IDLE. A frame is never truncated.
- Latency: from the first CS_SETUP cycle to temp_valid = 34*CLK_DIV+1 cycles (137 at default).
- Frame period with en held high = 34*CLK_DIV + 2 + SAMPLE_CYCLES cycles.
- sck and cs_n are registered (glitch-free). sck never toggles while cs_n=1.

Decomposition:
- Package lm70_pkg:
  - state enum
  - LM70_FRAME_BITS=16
  - TEMP_MSB=15, TEMP_LSB=7
  - ID_MSB=4, ID_LSB=2, ID_VAL=3'b111
- Sub-module lm70_sck_gen: CLK_DIV half-period counter that produces sck plus single-cycle rise_tick/fall_tick strobes. The FSM counts rise_ticks to 16.

Test Plan:
1. LM70 model returns 0x0C1F (24 C), setpoint=24, HYST=2 -> temp_out=24, over_temp=0, frame_err=0, temp_valid exactly 137 cycles after cs_n falls; exactly 16 sck rising edges while cs_n=0.
2. Sequence 0x0D1F (26), 0x0C9F (25), 0x0B9F (23), setpoint=24 -> over_temp goes 1, 1, 0 (hysteresis band holds at 25).
3. Word 0xFD9F (-5 C), setpoint=-3 -> temp_out=9'h1FB (-5), over_temp=0. Then setpoint=-128 with 0x0C1F -> over_temp=1, with no overflow at the signed extremes.
4. Word 0x0C00 (ID bits wrong) after a good 0x0D1F frame -> frame_err=1, temp_out stays 26, temp_valid still pulses once.
5. Assert rst mid-SHIFT (after 7 sck rises) -> cs_n=1 and sck=0 in the same cycle (async); the next frame after release starts cleanly from IDLE.
6. Drop en during SHIFT -> the frame finishes, temp_valid pulses, FSM returns to IDLE with no WAIT. With en held high, cs_n falls every 34*CLK_DIV+2+SAMPLE_CYCLES cycles.
